// File: rtl/channel_delay_ctrl_if.sv
// XGMII word stream into and out of the programmable delay channel.
// The slave side is the delay line; the master side is the word source and sink.
interface channel_delay_ctrl_if;
    logic [63:0] xge_rxd_i;
    logic [7:0]  xge_rxc_i;
    logic [63:0] xge_txd_o;
    logic [7:0]  xge_txc_o;

    modport slave (
        input  xge_rxd_i,
        input  xge_rxc_i,
        output xge_txd_o,
        output xge_txc_o
    );

    modport master (
        output xge_rxd_i,
        output xge_rxc_i,
        input  xge_txd_o,
        input  xge_txc_o
    );
endinterface

// File: rtl/channel_delay_ctrl.sv
// Programmable-latency XGMII channel: MAX_DELAY-stage register delay line with a runtime tap,
// where delay changes are applied only while every stage holds an idle word.
module channel_delay_ctrl #(
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 8,
    localparam int DLY_W        = $clog2(MAX_DELAY) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    channel_delay_ctrl_if.slave  xif,
    input  logic                 cfg_load_i,
    input  logic [DLY_W-1:0]     cfg_delay_i,
    output logic                 cfg_busy_o,
    output logic                 cfg_err_o,
    output logic [DLY_W-1:0]     cur_delay_o,
    output logic [15:0]          chg_cnt_o
);

    localparam logic [71:0]      IDLE_WORD = {8'hFF, 64'h0707070707070707};
    localparam logic [DLY_W-1:0] MAX_D     = DLY_W'(MAX_DELAY);
    localparam logic [DLY_W-1:0] DEF_D     = DLY_W'(DEFAULT_DELAY);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [71:0]      stage_q [1:MAX_DELAY];
    logic [71:0]      in_word;
    logic [71:0]      tap;
    logic             in_idle;
    logic             load_ok;

    state_t           state_q, state_d;
    logic [DLY_W-1:0] idle_run_q, idle_run_d;
    logic [DLY_W-1:0] pend_q, pend_d;
    logic [DLY_W-1:0] cur_q, cur_d;
    logic             err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;

    assign in_word = {xif.xge_rxc_i, xif.xge_rxd_i};
    assign in_idle = (in_word == IDLE_WORD);
    assign load_ok = cfg_load_i && (cfg_delay_i >= DLY_W'(1)) && (cfg_delay_i <= MAX_D);

    // Delay line: stage 1 captures the input word, the rest shift down by one each clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= MAX_DELAY; i++) begin
                stage_q[i] <= IDLE_WORD;
            end
        end else begin
            stage_q[1] <= in_word;
            for (int i = 2; i <= MAX_DELAY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        tap = IDLE_WORD;
        for (int i = 1; i <= MAX_DELAY; i++) begin
            if (cur_q == DLY_W'(i)) begin
                tap = stage_q[i];
            end
        end
    end

    assign xif.xge_txc_o = tap[71:64];
    assign xif.xge_txd_o = tap[63:0];

    // Saturating run length of idle input words; at MAX_DELAY the whole line is idle.
    always_comb begin
        if (!in_idle) begin
            idle_run_d = '0;
        end else if (idle_run_q == MAX_D) begin
            idle_run_d = MAX_D;
        end else begin
            idle_run_d = idle_run_q + DLY_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        err_d   = cfg_load_i && !load_ok;
        case (state_q)
            ST_STABLE: begin
                if (load_ok) begin
                    state_d = ST_PENDING;
                    pend_d  = cfg_delay_i;
                end
            end
            ST_PENDING: begin
                // A fresh load replaces the pending value and holds off the apply for this edge.
                if (load_ok) begin
                    pend_d = cfg_delay_i;
                end else if (!cfg_load_i && (idle_run_q == MAX_D)) begin
                    state_d = ST_STABLE;
                    cur_d   = pend_q;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_STABLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_STABLE;
            idle_run_q <= MAX_D;
            pend_q     <= DEF_D;
            cur_q      <= DEF_D;
            err_q      <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            idle_run_q <= idle_run_d;
            pend_q     <= pend_d;
            cur_q      <= cur_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cfg_busy_o  = (state_q == ST_PENDING);
    assign cfg_err_o   = err_q;
    assign cur_delay_o = cur_q;
    assign chg_cnt_o   = cnt_q;

endmodule
